// File: rtl/add_arb_pkg.sv
// Shared constants and the response-FIFO entry type for the add_arbiter slice.
package add_arb_pkg;

    localparam int CREDIT_DEPTH = 2;
    localparam int FIFO_DEPTH   = 2;
    localparam int PERF_CNT_W   = 16;
    localparam int RSP_DATA_W   = 32;
    localparam int RSP_ID_W     = 3;

    typedef struct packed {
        logic [RSP_DATA_W-1:0] data;
        logic [RSP_ID_W-1:0]   id;
        logic                  mode8;
    } rsp_entry_t;

endpackage

// File: rtl/add_arbiter_rr.sv
// Round-robin picker: searches from last_grant+1 upward and returns a one-hot grant
// plus its encoded index; no grant at all while enable is low.
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  valid,
    input  logic                enable,
    input  logic [ID_WIDTH-1:0] last_grant,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_id
);

    logic [ID_WIDTH-1:0] idx_s;
    logic                found_s;

    // first valid requester after the previous winner, wrapping mod NUM_REQ
    always_comb begin
        grant    = {NUM_REQ{1'b0}};
        grant_id = {ID_WIDTH{1'b0}};
        found_s  = 1'b0;
        idx_s    = {ID_WIDTH{1'b0}};
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s = ID_WIDTH'((int'(last_grant) + k) % NUM_REQ);
            if (enable && !found_s && valid[idx_s]) begin
                grant[idx_s] = 1'b1;
                grant_id     = idx_s;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/add_arbiter.sv
// Credit-based round-robin scheduler sharing one registered adder between requesters.
// Optional feature macro: ADD_ARB_PERF_EN (grant/stall counters with perf_sel/perf_data readout).
module add_arbiter
    import add_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ID_WIDTH  = 2,
    parameter int IN1_WIDTH = 20,
    parameter int IN2_WIDTH = 32,
    parameter int OUT_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_mode8,
    input  logic [NUM_REQ*IN1_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*IN2_WIDTH-1:0]   req_b,
    output logic                           add_enable,
    output logic [IN1_WIDTH-1:0]           add_a,
    output logic [IN2_WIDTH-1:0]           add_b,
    output logic                           add_choose_8bit,
    input  logic [OUT_WIDTH-1:0]           add_out,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [OUT_WIDTH-1:0]           rsp_data,
    output logic [ID_WIDTH-1:0]            rsp_id,
    output logic                           rsp_mode8
`ifdef ADD_ARB_PERF_EN
    ,
    input  logic [ID_WIDTH:0]              perf_sel,
    output logic [PERF_CNT_W-1:0]          perf_data
`endif
);

    logic [1:0]          credit_q, credit_d;
    logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;
    logic                infl_valid_q, infl_valid_d;
    logic [ID_WIDTH-1:0] infl_id_q, infl_id_d;
    logic                infl_mode8_q, infl_mode8_d;
    rsp_entry_t          fifo_q [FIFO_DEPTH];
    rsp_entry_t          fifo_d [FIFO_DEPTH];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          count_q, count_d;

    logic                rsp_valid_s, rsp_hs_s, credit_ok_s, issue_s;
    logic [NUM_REQ-1:0]  grant_s;
    logic [ID_WIDTH-1:0] grant_id_s;
    rsp_entry_t          head_s, push_entry_s;

    // a handshake in this cycle frees a slot early, so it also counts as credit
    always_comb begin
        rsp_valid_s = (count_q != 2'd0);
        rsp_hs_s    = rsp_valid_s && rsp_ready;
        credit_ok_s = !reset && ((credit_q != 2'd0) || rsp_hs_s);
    end

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr (
        .valid      (req_valid),
        .enable     (credit_ok_s),
        .last_grant (last_grant_q),
        .grant      (grant_s),
        .grant_id   (grant_id_s)
    );

    // adder-side pins; the mode select follows the in-flight op while its result is on add_out
    always_comb begin
        issue_s    = |grant_s;
        req_ready  = grant_s;
        add_enable = issue_s;
        if (issue_s) begin
            add_a = req_a[grant_id_s*IN1_WIDTH +: IN1_WIDTH];
            add_b = req_b[grant_id_s*IN2_WIDTH +: IN2_WIDTH];
        end else begin
            add_a = {IN1_WIDTH{1'b0}};
            add_b = {IN2_WIDTH{1'b0}};
        end
        if (infl_valid_q) begin
            add_choose_8bit = infl_mode8_q;
        end else if (issue_s) begin
            add_choose_8bit = req_mode8[grant_id_s];
        end else begin
            add_choose_8bit = 1'b0;
        end
    end

    // credit, arbitration pointer and in-flight tracking
    always_comb begin
        case ({issue_s, rsp_hs_s})
            2'b10:   credit_d = credit_q - 2'd1;
            2'b01:   credit_d = credit_q + 2'd1;
            default: credit_d = credit_q;
        endcase
        if (issue_s) begin
            last_grant_d = grant_id_s;
            infl_mode8_d = req_mode8[grant_id_s];
        end else begin
            last_grant_d = last_grant_q;
            infl_mode8_d = 1'b0;
        end
        infl_valid_d = issue_s;
        infl_id_d    = grant_id_s;
    end

    // response FIFO; credits bound occupancy so a push never meets a full FIFO
    always_comb begin
        push_entry_s = '{data: RSP_DATA_W'(add_out), id: RSP_ID_W'(infl_id_q), mode8: infl_mode8_q};
        fifo_d       = fifo_q;
        if (infl_valid_q) begin
            fifo_d[wr_ptr_q] = push_entry_s;
            wr_ptr_d         = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rsp_hs_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + {1'b0, infl_valid_q} - {1'b0, rsp_hs_s};
    end

    // head presentation; fields read as zero when the FIFO is empty
    always_comb begin
        head_s    = fifo_q[rd_ptr_q];
        rsp_valid = rsp_valid_s;
        if (rsp_valid_s) begin
            rsp_data  = OUT_WIDTH'(head_s.data);
            rsp_id    = ID_WIDTH'(head_s.id);
            rsp_mode8 = head_s.mode8;
        end else begin
            rsp_data  = {OUT_WIDTH{1'b0}};
            rsp_id    = {ID_WIDTH{1'b0}};
            rsp_mode8 = 1'b0;
        end
    end

    // state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            credit_q     <= 2'(CREDIT_DEPTH);
            last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
            infl_valid_q <= 1'b0;
            infl_id_q    <= {ID_WIDTH{1'b0}};
            infl_mode8_q <= 1'b0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= {$bits(rsp_entry_t){1'b0}};
            end
        end else begin
            credit_q     <= credit_d;
            last_grant_q <= last_grant_d;
            infl_valid_q <= infl_valid_d;
            infl_id_q    <= infl_id_d;
            infl_mode8_q <= infl_mode8_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            fifo_q       <= fifo_d;
        end
    end

`ifdef ADD_ARB_PERF_EN
    logic [PERF_CNT_W-1:0] grant_cnt_q [NUM_REQ];
    logic [PERF_CNT_W-1:0] grant_cnt_d [NUM_REQ];
    logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_CNT_W-1:0] perf_data_q, perf_data_d;

    // saturating grant/stall counters and the registered readout mux
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i] && (grant_cnt_q[i] != {PERF_CNT_W{1'b1}})) begin
                grant_cnt_d[i] = grant_cnt_q[i] + {{(PERF_CNT_W-1){1'b0}}, 1'b1};
            end else begin
                grant_cnt_d[i] = grant_cnt_q[i];
            end
        end
        if ((|req_valid) && !credit_ok_s && (stall_cnt_q != {PERF_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(PERF_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (perf_sel < (ID_WIDTH+1)'(NUM_REQ)) begin
            perf_data_d = grant_cnt_q[perf_sel[ID_WIDTH-1:0]];
        end else if (perf_sel == (ID_WIDTH+1)'(NUM_REQ)) begin
            perf_data_d = stall_cnt_q;
        end else begin
            perf_data_d = {PERF_CNT_W{1'b0}};
        end
    end

    // performance registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt_q[i] <= {PERF_CNT_W{1'b0}};
            end
            stall_cnt_q <= {PERF_CNT_W{1'b0}};
            perf_data_q <= {PERF_CNT_W{1'b0}};
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            perf_data_q <= perf_data_d;
        end
    end

    assign perf_data = perf_data_q;
`endif

endmodule
